dram_port_ctrl: RTL and testbench

Memory-side access controller sitting directly downstream of the core bus arbiter. It consumes the arbitrated DRAM request (address, write data, load/store trigger, size code) and drives a 32-bit word-wide backing memory through a req/ack handshake. It generates the busy and load-data signals that the arbiter returns to the granted core. Sub-word and misaligned accesses are handled here; misaligned accesses that cross a word boundary are split into two memory beats.

---
 rtl/dram_port_pkg.sv | 26 ++
 rtl/dram_lane_align.sv | 41 ++++
 rtl/dram_port_ctrl.sv | 125 ++++++++++++
 tb/tb_dram_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_port_pkg.sv
// Shared definitions for the DRAM port controller: size codes, FSM encoding
// and the access-size decode.
package dram_port_pkg;

  localparam logic [2:0] CTRL_LB  = 3'b000;
  localparam logic [2:0] CTRL_LH  = 3'b001;
  localparam logic [2:0] CTRL_LW  = 3'b010;
  localparam logic [2:0] CTRL_LBU = 3'b100;
  localparam logic [2:0] CTRL_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  // Unlisted codes (011, 110, 111) fall into the word case.
  function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dram_lane_align.sv
// Byte-lane steering for the DRAM port: store shift/enables across two words,
// load extraction from a two-word window and sign/zero extension.
module dram_lane_align
  import dram_port_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  ctrl,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  output logic        split,
  output logic [63:0] wdata64,
  output logic [7:0]  be8,
  output logic [31:0] ldata
);

  logic [2:0]  size;
  logic [3:0]  m;
  logic [31:0] raw;
  logic        sext;

  always_comb begin
    size = size_bytes(ctrl);
    sext = (ctrl == CTRL_LB) || (ctrl == CTRL_LH);
    case (size)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    split   = ({2'b00, off} + {1'b0, size}) > 4'd4;
    wdata64 = {32'b0, wdata} << {off, 3'b000};
    be8     = {4'b0000, m} << off;
    // Low half is the first beat, high half the second (zero when unsplit).
    raw     = rdata64[{off, 3'b000} +: 32];
    case (size)
      3'd1:    ldata = sext ? {{24{raw[7]}}, raw[7:0]}   : {24'b0, raw[7:0]};
      3'd2:    ldata = sext ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      default: ldata = raw;
    endcase
  end

endmodule

// File: rtl/dram_port_ctrl.sv
// Arbiter-facing DRAM access controller: turns byte-addressed load/store
// triggers into one or two word beats on a req/ack memory port.
module dram_port_ctrl
  import dram_port_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] w_dram_addr,
  input  logic [31:0]       w_dram_wdata,
  input  logic              w_dram_we_t,
  input  logic              w_dram_le,
  input  logic [2:0]        w_dram_ctrl,
  output logic [31:0]       w_dram_odata,
  output logic              w_dram_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output state_t            dbg_state
);

  // Memory handshake: mem_req rises with BEAT0 and holds until the cycle
  // after the final mem_ack; beat fields are stable while req=1 and ack=0.
  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata0_q, odata_q;
  logic [2:0]        ctrl_q;
  logic              we_q;
  logic              capture, save0, finish;
  logic              active, beat1, split;
  logic [63:0]       rdata64, wdata64;
  logic [7:0]        be8;
  logic [31:0]       ldata;

  assign active  = (state_q != IDLE);
  assign beat1   = (state_q == BEAT1);
  assign rdata64 = beat1 ? {mem_rdata, rdata0_q} : {32'b0, mem_rdata};

  dram_lane_align u_align (
    .off     (addr_q[1:0]),
    .ctrl    (ctrl_q),
    .wdata   (wdata_q),
    .rdata64 (rdata64),
    .split   (split),
    .wdata64 (wdata64),
    .be8     (be8),
    .ldata   (ldata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    capture = 1'b0;
    save0   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (w_dram_le | w_dram_we_t) begin
        capture = 1'b1;
        state_d = BEAT0;
        req_d   = 1'b1;
      end
      BEAT0: if (mem_ack) begin
        if (split) begin
          save0   = 1'b1;
          state_d = BEAT1;
        end else begin
          finish  = 1'b1;
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      BEAT1: if (mem_ack) begin
        finish  = 1'b1;
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ctrl_q   <= '0;
      we_q     <= 1'b0;
      rdata0_q <= '0;
      odata_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (capture) begin
        addr_q  <= w_dram_addr;
        wdata_q <= w_dram_wdata;
        ctrl_q  <= w_dram_ctrl;
        we_q    <= w_dram_we_t;
      end
      if (save0) rdata0_q <= mem_rdata;
      if (finish && !we_q) odata_q <= ldata;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = active & we_q;
  assign mem_addr     = beat1 ? addr_q[ADDR_W-1:2] + WORD_ONE : addr_q[ADDR_W-1:2];
  assign mem_wdata    = !(active & we_q) ? 32'b0 : (beat1 ? wdata64[63:32] : wdata64[31:0]);
  assign mem_be       = !active ? 4'b0000 : (!we_q ? 4'b1111 : (beat1 ? be8[7:4] : be8[3:0]));
  assign w_dram_busy  = active | ((w_dram_le | w_dram_we_t) & !active);
  assign w_dram_odata = odata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dram_port_ctrl.sv
// Scoreboard bench for dram_port_ctrl: directed accesses against a small
// word memory with programmable ack delay.
module tb_dram_port_ctrl;
  import dram_port_pkg::*;

  logic        clk, rst;
  logic [31:0] w_dram_addr, w_dram_wdata;
  logic        w_dram_we_t, w_dram_le;
  logic [2:0]  w_dram_ctrl;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  state_t      dbg_state;

  logic        resp_ack, stray_ack;
  int          mem_wait;
  int          cyc;
  int          n_cmp, n_err;
  logic [31:0] mem_arr [logic [29:0]];

  // {we, word addr, be, wdata}
  logic [66:0] exp_beat_q [$];
  logic [31:0] exp_odata_q [$];
  int          exp_lat_q [$];
  int          trig_q [$];

  assign mem_ack = resp_ack | stray_ack;

  dram_port_ctrl #(.ADDR_W(32)) dut (
    .CLK          (clk),
    .RST          (rst),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_we_t  (w_dram_we_t),
    .w_dram_le    (w_dram_le),
    .w_dram_ctrl  (w_dram_ctrl),
    .w_dram_odata (w_dram_odata),
    .w_dram_busy  (w_dram_busy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory responder: acks after mem_wait idle request cycles
  initial begin
    int wcnt;
    wcnt = 0;
    resp_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (mem_req && !rst) begin
        if (wcnt < mem_wait) wcnt++;
        else begin
          resp_ack  = 1'b1;
          mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
          wcnt      = 0;
        end
      end else wcnt = 0;
    end
  end

  // beat monitor: head of queue must match every request cycle
  always @(negedge clk) begin
    if (!rst && mem_req) begin
      if (exp_beat_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected: got addr %0h be %0h we %0b expected no request", mem_addr, mem_be, mem_we);
      end else begin
        logic [66:0] e;
        e = exp_beat_q[0];
        chk("beat_we", 64'(mem_we), 64'(e[66]));
        chk("beat_addr", 64'(mem_addr), 64'(e[65:36]));
        chk("beat_be", 64'(mem_be), 64'(e[35:32]));
        if (e[66]) chk("beat_wdata", 64'(mem_wdata), 64'(e[31:0]));
        chk("busy_hold", 64'(w_dram_busy), 64'd1);
        if (mem_ack) void'(exp_beat_q.pop_front());
      end
    end
  end

  // completion monitor: odata, latency and busy on return to IDLE
  always @(negedge clk) begin
    static bit prev_active = 1'b0;
    if (rst) prev_active = 1'b0;
    else begin
      if (prev_active && dbg_state == IDLE) begin
        if (exp_odata_q.size() == 0 || trig_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done_unexpected: got completion expected none");
        end else begin
          chk("odata", 64'(w_dram_odata), 64'(exp_odata_q.pop_front()));
          chk("latency", 64'(cyc - trig_q.pop_front()), 64'(exp_lat_q.pop_front()));
          chk("busy_done", 64'(w_dram_busy), 64'(w_dram_le | w_dram_we_t));
        end
      end
      prev_active = (dbg_state != IDLE);
    end
  end

  // driver tasks
  task automatic push_beat(input logic we, input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_beat_q.push_back({we, a, be, d});
  endtask

  task automatic push_done(input logic [31:0] od, input int lat);
    exp_odata_q.push_back(od);
    exp_lat_q.push_back(lat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dbg_state != IDLE && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got state %0d expected IDLE within 200 cycles", dbg_state);
    end
  endtask

  task automatic issue(input logic we, input logic le, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl);
    wait_idle();
    w_dram_addr  = addr;
    w_dram_wdata = wdata;
    w_dram_ctrl  = ctrl;
    w_dram_we_t  = we;
    w_dram_le    = le;
    trig_q.push_back(cyc);
    @(posedge clk);
    #1;
    w_dram_we_t = 1'b0;
    w_dram_le   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem_wait = 0;
    stray_ack = 1'b0;
    w_dram_addr = '0;
    w_dram_wdata = '0;
    w_dram_ctrl = '0;
    w_dram_we_t = 1'b0;
    w_dram_le = 1'b0;
    mem_arr[30'h0]        = 32'h11AABBCC;
    mem_arr[30'h1]        = 32'h55667722;
    mem_arr[30'h40]       = 32'hDEADBEEF;
    mem_arr[30'h80]       = 32'h80123456;
    mem_arr[30'h3FFFFFFF] = 32'h12345678;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_odata", 64'(w_dram_odata), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_be", 64'(mem_be), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(w_dram_busy), 64'd0);

    // LW aligned
    push_beat(1'b0, 30'h40, 4'hF, 32'h0);
    push_done(32'hDEADBEEF, 2);
    issue(1'b0, 1'b1, 32'h100, 32'h0, CTRL_LW);
    // LB / LBU on top byte
    push_beat(1'b0, 30'h80, 4'hF, 32'h0);
    push_done(32'hFFFFFF80, 2);
    issue(1'b0, 1'b1, 32'h203, 32'h0, CTRL_LB);
    push_beat(1'b0, 30'h80, 4'hF, 32'h0);
    push_done(32'h00000080, 2);
    issue(1'b0, 1'b1, 32'h203, 32'h0, CTRL_LBU);
    // SH upper half, odata untouched
    push_beat(1'b1, 30'h40, 4'b1100, 32'h12340000);
    push_done(32'h00000080, 2);
    issue(1'b1, 1'b0, 32'h102, 32'h1234, CTRL_LH);
    // SW misaligned, two beats
    push_beat(1'b1, 30'h40, 4'b1110, 32'hBBCCDD00);
    push_beat(1'b1, 30'h41, 4'b0001, 32'h000000AA);
    push_done(32'h00000080, 3);
    issue(1'b1, 1'b0, 32'h101, 32'hAABBCCDD, CTRL_LW);
    // LH split with 3 wait cycles per beat
    wait_idle();
    mem_wait = 3;
    push_beat(1'b0, 30'h0, 4'hF, 32'h0);
    push_beat(1'b0, 30'h1, 4'hF, 32'h0);
    push_done(32'h00002211, 9);
    issue(1'b0, 1'b1, 32'h003, 32'h0, CTRL_LH);
    wait_idle();
    mem_wait = 0;
    // simultaneous triggers: store only
    push_beat(1'b1, 30'h80, 4'hF, 32'h11223344);
    push_done(32'h00002211, 2);
    issue(1'b1, 1'b1, 32'h200, 32'h11223344, CTRL_LW);
    // LH ending exactly at word boundary, no split
    push_beat(1'b0, 30'h40, 4'hF, 32'h0);
    push_done(32'hFFFFDEAD, 2);
    issue(1'b0, 1'b1, 32'h102, 32'h0, CTRL_LH);
    // SB to lane 3
    push_beat(1'b1, 30'h0, 4'b1000, 32'hA5000000);
    push_done(32'hFFFFDEAD, 2);
    issue(1'b1, 1'b0, 32'h003, 32'hFFFFFFA5, CTRL_LB);
    // LW split across the top of the address space
    push_beat(1'b0, 30'h3FFFFFFF, 4'hF, 32'h0);
    push_beat(1'b0, 30'h0, 4'hF, 32'h0);
    push_done(32'hBBCC1234, 3);
    issue(1'b0, 1'b1, 32'hFFFFFFFE, 32'h0, CTRL_LW);

    // reset in the middle of BEAT0
    wait_idle();
    @(posedge clk);
    #1;
    mem_wait = 1000;
    push_beat(1'b0, 30'h40, 4'hF, 32'h0);
    issue(1'b0, 1'b1, 32'h100, 32'h0, CTRL_LW);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", 64'(mem_req), 64'd0);
    chk("midrst_busy", 64'(w_dram_busy), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_beat_q.delete();
    trig_q.delete();
    mem_wait = 0;
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    chk("stray_state", 64'(dbg_state), 64'(IDLE));
    chk("stray_req", 64'(mem_req), 64'd0);
    chk("stray_odata", 64'(w_dram_odata), 64'd0);

    // normal operation after reset
    push_beat(1'b0, 30'h40, 4'hF, 32'h0);
    push_done(32'hDEADBEEF, 2);
    issue(1'b0, 1'b1, 32'h100, 32'h0, CTRL_LW);

    begin
      int n;
      n = 0;
      while ((exp_beat_q.size() != 0 || exp_odata_q.size() != 0) && n < 500) begin
        @(posedge clk);
        n++;
      end
      @(posedge clk);
      chk("drain_beats", 64'(exp_beat_q.size()), 64'd0);
      chk("drain_done", 64'(exp_odata_q.size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
